// File: rtl/mat_vec_mult_param_if.sv
// Host-side bus for mat_vec_mult_param: load path, control
// handshake and result readout.
interface mat_vec_mult_param_if #(
  parameter int ROWS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH
) ();
  logic                      clr;
  logic [ROWS-1:0]           a_wren;
  logic [DATA_WIDTH-1:0]     a_fifo_in;
  logic                      b_wren;
  logic [DATA_WIDTH-1:0]     b_fifo_in;
  logic [ROWS-1:0]           a_full;
  logic                      b_full;
  logic                      start;
  logic                      busy;
  logic                      done;
  logic [ROWS*ACC_WIDTH-1:0] out;

  modport master (
    output clr, a_wren, a_fifo_in,
    output b_wren, b_fifo_in, start,
    input  a_full, b_full, busy, done, out
  );

  modport slave (
    input  clr, a_wren, a_fifo_in,
    input  b_wren, b_fifo_in, start,
    output a_full, b_full, busy, done, out
  );
endinterface

// File: rtl/mat_vec_mult_param.sv
// ROWS x COLS matrix-vector multiplier: one FIFO per matrix row,
// one shared vector FIFO broadcast to ROWS MAC lanes.
module mat_vec_mult_param #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH,
  parameter bit SIGNED     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  mat_vec_mult_param_if.slave bus
);
  localparam int CW = $clog2(COLS+1);
  localparam int KW = $clog2(COLS);
  localparam int PW = 2*DATA_WIDTH;
  localparam int XW = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;
  localparam logic [CW-1:0] FULL_CNT = CW'(COLS);
  localparam logic [KW-1:0] K_LAST   = KW'(COLS-1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0] k_q, k_d;
  logic          accept;
  logic          last;
  logic          idle_wr;
  logic          all_full;

  logic [CW-1:0]         a_cnt_q [ROWS];
  logic [CW-1:0]         b_cnt_q;
  logic [DATA_WIDTH-1:0] a_mem_q [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_mem_q [COLS];

  logic [ROWS-1:0]       a_wr;
  logic [ROWS-1:0]       a_full_w;
  logic                  b_wr;
  logic                  b_full_w;
  logic [DATA_WIDTH-1:0] b_el;
  logic [XW-1:0]         prod [ROWS];

  logic [ACC_WIDTH-1:0]      acc_q [ROWS];
  logic [ROWS*ACC_WIDTH-1:0] out_q;
  logic                      done_q;

  // The FIFOs are read in lock-step from a shared pointer k, so
  // occupancy is COLS-k during COMPUTE and only k==0 reads as full.
  assign last     = (state_q == COMPUTE) && (k_q == K_LAST);
  assign idle_wr  = (state_q == IDLE) && !bus.clr;
  assign b_full_w = (b_cnt_q == FULL_CNT) &&
                    (state_q != COMPUTE || k_q == '0);
  assign b_wr     = idle_wr && bus.b_wren && !b_full_w;
  assign b_el     = b_mem_q[k_q];
  assign all_full = (&a_full_w) && b_full_w;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_WIDTH-1:0] a_el;
    assign a_el = a_mem_q[r][k_q];
    assign a_full_w[r] = (a_cnt_q[r] == FULL_CNT) &&
                         (state_q != COMPUTE || k_q == '0);
    assign a_wr[r] = idle_wr && bus.a_wren[r] && !a_full_w[r];
    if (SIGNED) begin : g_s
      assign prod[r] = XW'($signed(a_el)) * XW'($signed(b_el));
    end else begin : g_u
      assign prod[r] = XW'(a_el) * XW'(b_el);
    end
  end

  assign bus.a_full = a_full_w;
  assign bus.b_full = b_full_w;
  assign bus.busy   = (state_q == COMPUTE);
  assign bus.done   = done_q;
  assign bus.out    = out_q;

  // State and column pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next state; clr overrides everything and returns to IDLE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && all_full) begin
          state_d = COMPUTE;
          k_d     = '0;
          accept  = 1'b1;
        end
      end
      COMPUTE: begin
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = DONE;
          k_d     = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
    if (bus.clr) begin
      state_d = IDLE;
      k_d     = '0;
      accept  = 1'b0;
    end
  end

  // FIFO occupancy: grows on IDLE writes, empties after the last pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) a_cnt_q[r] <= '0;
      b_cnt_q <= '0;
    end else if (bus.clr || last) begin
      for (int r = 0; r < ROWS; r++) a_cnt_q[r] <= '0;
      b_cnt_q <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (a_wr[r]) a_cnt_q[r] <= a_cnt_q[r] + CW'(1);
      end
      if (b_wr) b_cnt_q <= b_cnt_q + CW'(1);
    end
  end

  // FIFO storage; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (a_wr[r]) a_mem_q[r][a_cnt_q[r][KW-1:0]] <= bus.a_fifo_in;
    end
    if (b_wr) b_mem_q[b_cnt_q[KW-1:0]] <= bus.b_fifo_in;
  end

  // MAC lanes: zeroed on start, one product per COMPUTE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) acc_q[r] <= '0;
    end else if (bus.clr || accept) begin
      for (int r = 0; r < ROWS; r++) acc_q[r] <= '0;
    end else if (state_q == COMPUTE) begin
      for (int r = 0; r < ROWS; r++) begin
        acc_q[r] <= acc_q[r] + ACC_WIDTH'(prod[r]);
      end
    end
  end

  // Result register and done pulse, both loaded leaving DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      done_q <= 1'b0;
    end else if (bus.clr) begin
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      if (state_q == DONE) begin
        for (int r = 0; r < ROWS; r++) begin
          out_q[r*ACC_WIDTH +: ACC_WIDTH] <= acc_q[r];
        end
      end
    end
  end
endmodule

// File: tb/tb_mat_vec_mult_param.sv
// Bench for mat_vec_mult_param: three instances (unsigned/24,
// signed/24, unsigned/16) share one stimulus stream.
module tb_mat_vec_mult_param;
  localparam int R  = 8;
  localparam int C  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          start;
  logic          b_wren;
  logic [R-1:0]  a_wren;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;

  int checks = 0;
  int errors = 0;
  int qa [R][$];
  int qb [$];
  logic [191:0] held0, held1, held2;

  always #5 clk = ~clk;

  mat_vec_mult_param_if #(.ROWS(R), .DATA_WIDTH(DW), .ACC_WIDTH(24)) if0 ();
  mat_vec_mult_param_if #(.ROWS(R), .DATA_WIDTH(DW), .ACC_WIDTH(24)) if1 ();
  mat_vec_mult_param_if #(.ROWS(R), .DATA_WIDTH(DW), .ACC_WIDTH(16)) if2 ();

  assign if0.clr = clr;
  assign if0.start = start;
  assign if0.a_wren = a_wren;
  assign if0.a_fifo_in = a_in;
  assign if0.b_wren = b_wren;
  assign if0.b_fifo_in = b_in;
  assign if1.clr = clr;
  assign if1.start = start;
  assign if1.a_wren = a_wren;
  assign if1.a_fifo_in = a_in;
  assign if1.b_wren = b_wren;
  assign if1.b_fifo_in = b_in;
  assign if2.clr = clr;
  assign if2.start = start;
  assign if2.a_wren = a_wren;
  assign if2.a_fifo_in = a_in;
  assign if2.b_wren = b_wren;
  assign if2.b_fifo_in = b_in;

  mat_vec_mult_param #(
    .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(24), .SIGNED(1'b0)
  ) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mat_vec_mult_param #(
    .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(24), .SIGNED(1'b1)
  ) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mat_vec_mult_param #(
    .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(16), .SIGNED(1'b0)
  ) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // Reference: dot product of queued rows with queued vector, mod 2^accw.
  function automatic logic [191:0] model(bit sgn, int accw);
    logic [191:0] v = '0;
    for (int r = 0; r < R; r++) begin
      longint s = 0;
      for (int c = 0; c < C; c++) begin
        longint a = qa[r][c];
        longint b = qb[c];
        if (sgn && a > 127) a -= 256;
        if (sgn && b > 127) b -= 256;
        s += a * b;
      end
      v |= 192'(s & ((longint'(1) << accw) - 1)) << (r * accw);
    end
    return v;
  endfunction

  task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_flags(string tag, logic [R-1:0] af, logic bf,
                           logic bz, logic dn);
    logic [191:0] e = 192'({af, bf, bz, dn});
    chk({tag, "_f0"}, 192'({if0.a_full, if0.b_full, if0.busy, if0.done}), e);
    chk({tag, "_f1"}, 192'({if1.a_full, if1.b_full, if1.busy, if1.done}), e);
    chk({tag, "_f2"}, 192'({if2.a_full, if2.b_full, if2.busy, if2.done}), e);
  endtask

  task automatic chk_out(string tag);
    chk({tag, "_o0"}, if0.out, held0);
    chk({tag, "_o1"}, if1.out, held1);
    chk({tag, "_o2"}, 192'(if2.out), held2);
  endtask

  task automatic drop_model();
    for (int r = 0; r < R; r++) qa[r].delete();
    qb.delete();
  endtask

  task automatic write_a(logic [R-1:0] m, logic [DW-1:0] v);
    for (int r = 0; r < R; r++) begin
      if (m[r] && qa[r].size() < C) qa[r].push_back(int'(v));
    end
    a_wren = m;
    a_in = v;
    tick();
    a_wren = '0;
  endtask

  task automatic write_b(logic [DW-1:0] v);
    if (qb.size() < C) qb.push_back(int'(v));
    b_wren = 1'b1;
    b_in = v;
    tick();
    b_wren = 1'b0;
  endtask

  task automatic load_random();
    for (int c = 0; c < C; c++) begin
      for (int r = 0; r < R; r++) write_a(R'(1) << r, DW'($urandom));
      write_b(DW'($urandom));
    end
  endtask

  // Start a full load, optionally hammer writes while busy, check result.
  task automatic run(string tag, bit junk);
    int n = 0;
    logic [191:0] e0, e1, e2;
    e0 = model(1'b0, 24);
    e1 = model(1'b1, 24);
    e2 = model(1'b0, 16);
    drop_model();
    chk_flags({tag, "_pre"}, '1, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_flags({tag, "_go"}, '1, 1'b1, 1'b1, 1'b0);
    if (junk) begin
      a_wren = '1;
      b_wren = 1'b1;
      a_in = 8'h5A;
      b_in = 8'hA5;
    end
    while (!(if0.done || if1.done || if2.done) && n < 3*C) begin
      tick();
      n++;
      if (junk && n >= C) begin
        a_wren = '0;
        b_wren = 1'b0;
      end
      if (n == 1) begin
        chk_flags({tag, "_mid"}, '0, 1'b0, 1'b1, 1'b0);
        chk_out({tag, "_hold"});
      end
      if (n == C) chk_flags({tag, "_dst"}, '0, 1'b0, 1'b0, 1'b0);
    end
    a_wren = '0;
    b_wren = 1'b0;
    chk({tag, "_lat"}, 192'(n), 192'(C + 1));
    held0 = e0;
    held1 = e1;
    held2 = e2;
    chk_flags({tag, "_done"}, '0, 1'b0, 1'b0, 1'b1);
    chk_out({tag, "_res"});
    tick();
    chk_flags({tag, "_pulse"}, '0, 1'b0, 1'b0, 1'b0);
    chk_out({tag, "_keep"});
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    clr = 1'b0;
    start = 1'b0;
    a_wren = '0;
    b_wren = 1'b0;
    a_in = '0;
    b_in = '0;
    held0 = '0;
    held1 = '0;
    held2 = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_flags("reset", '0, 1'b0, 1'b0, 1'b0);
    chk_out("reset");

    // Broadcast rows [0..7], vector [1..8].
    for (int c = 0; c < C; c++) write_a('1, DW'(c));
    for (int c = 0; c < C; c++) write_b(DW'(c + 1));
    run("dflt", 1'b0);

    // Overfill row 0; the ninth write must be dropped.
    for (int c = 0; c < C; c++) write_a(8'hFE, DW'(c));
    for (int c = 0; c < C - 1; c++) write_a(8'h01, DW'(c));
    chk_flags("ovf7", 8'hFE, 1'b0, 1'b0, 1'b0);
    write_a(8'h01, DW'(C - 1));
    chk_flags("ovf8", 8'hFF, 1'b0, 1'b0, 1'b0);
    write_a(8'h01, 8'd99);
    chk_flags("ovf9", 8'hFF, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < C; c++) write_b(DW'(c + 1));
    run("ovf", 1'b0);

    // Start without a full vector is ignored.
    for (int c = 0; c < C; c++) write_a('1, DW'($urandom));
    start = 1'b1;
    tick();
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (if0.busy || if0.done || if1.busy || if1.done ||
          if2.busy || if2.done) bad++;
      tick();
    end
    chk("nostart", 192'(bad), 192'(0));
    chk_flags("nostart", '1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < C; c++) write_b(DW'($urandom));
    run("late", 1'b0);

    // -1 * 2 per column, and the 0xFF*0xFF wrap case.
    for (int c = 0; c < C; c++) write_a('1, 8'hFF);
    for (int c = 0; c < C; c++) write_b(8'h02);
    run("sgn", 1'b0);
    for (int c = 0; c < C; c++) write_a('1, 8'hFF);
    for (int c = 0; c < C; c++) write_b(8'hFF);
    run("wrap", 1'b0);

    for (int i = 0; i < 3; i++) begin
      load_random();
      run("rand", i == 1);
    end

    // clr together with start and writes: FIFOs empty, no compute.
    load_random();
    clr = 1'b1;
    start = 1'b1;
    a_wren = '1;
    b_wren = 1'b1;
    tick();
    clr = 1'b0;
    start = 1'b0;
    a_wren = '0;
    b_wren = 1'b0;
    drop_model();
    held0 = '0;
    held1 = '0;
    held2 = '0;
    chk_flags("clridle", '0, 1'b0, 1'b0, 1'b0);
    chk_out("clridle");

    // clr in the third COMPUTE cycle.
    load_random();
    run("pre_clr", 1'b0);
    load_random();
    drop_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    held0 = '0;
    held1 = '0;
    held2 = '0;
    chk_flags("clrmid", '0, 1'b0, 1'b0, 1'b0);
    chk_out("clrmid");
    bad = 0;
    for (int i = 0; i < 2*C; i++) begin
      if (if0.done || if1.done || if2.done) bad++;
      tick();
    end
    chk("clr_nodone", 192'(bad), 192'(0));

    // Asynchronous reset in the middle of COMPUTE.
    load_random();
    run("pre_rst", 1'b0);
    load_random();
    drop_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    held0 = '0;
    held1 = '0;
    held2 = '0;
    chk_flags("arst", '0, 1'b0, 1'b0, 1'b0);
    chk_out("arst");
    tick();
    rst = 1'b0;
    tick();

    load_random();
    run("post_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
